// File: rtl/mac_result_accumulator.sv
// Sums LEN consecutive multiply-add results into one frame total and presents it on a
// valid/ready handshake with sticky overflow and drop flags.
module mac_result_accumulator #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN   = 4,
    parameter int unsigned GUARD = 2,
    localparam int unsigned ACC_W = 2 * WIDTH + GUARD,
    localparam int unsigned CNT_W = $clog2(LEN + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic [2*WIDTH-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               ovf,
    output logic               drop_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(LEN - 1);

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             out_valid_q, out_valid_d;
    logic             ovf_q, ovf_d;
    logic             drop_q, drop_d;

    logic [ACC_W-1:0] in_ext;
    logic [ACC_W:0]   sum_full;
    logic             accept;

    assign in_ready = (state_q != HOLD);
    assign accept   = in_valid && in_ready && !clear;
    assign in_ext   = ACC_W'(in_data);
    // Extra top bit captures the carry out of the accumulator width.
    assign sum_full = {1'b0, acc_q} + {1'b0, in_ext};

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_sum_d   = out_sum_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        drop_d      = drop_q;

        if (clear) begin
            state_d     = IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            ovf_d       = 1'b0;
            drop_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (LEN == 1) begin
                            out_sum_d   = in_ext;
                            out_valid_d = 1'b1;
                            acc_d       = '0;
                            cnt_d       = '0;
                            state_d     = HOLD;
                        end else begin
                            acc_d   = in_ext;
                            cnt_d   = CNT_W'(1);
                            state_d = ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        ovf_d = ovf_q | sum_full[ACC_W];
                        if (cnt_q == LastCnt) begin
                            out_sum_d   = sum_full[ACC_W-1:0];
                            out_valid_d = 1'b1;
                            acc_d       = '0;
                            cnt_d       = '0;
                            state_d     = HOLD;
                        end else begin
                            acc_d = sum_full[ACC_W-1:0];
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (in_valid) begin
                        drop_d = 1'b1;
                    end
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_sum_q   <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_sum_q   <= out_sum_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
        end
    end

    assign out_sum   = out_sum_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;
    assign drop_err  = drop_q;

endmodule

// File: tb/tb_mac_result_accumulator.sv
// Bench for mac_result_accumulator: two instances (GUARD=2 and GUARD=1) share stimulus;
// frame totals go through a scoreboard, control behaviour is checked directly.
module tb_mac_result_accumulator;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned LEN   = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;

    logic        a_in_ready, a_out_valid, a_ovf, a_drop;
    logic [17:0] a_out_sum;
    logic        b_in_ready, b_out_valid, b_ovf, b_drop;
    logic [16:0] b_out_sum;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int unsigned sa;
        bit          oa;
        int unsigned sb;
        bit          ob;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    mac_result_accumulator #(.WIDTH(WIDTH), .LEN(LEN), .GUARD(2)) u_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (a_in_ready),
        .out_sum   (a_out_sum),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .ovf       (a_ovf),
        .drop_err  (a_drop)
    );

    mac_result_accumulator #(.WIDTH(WIDTH), .LEN(LEN), .GUARD(1)) u_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (b_in_ready),
        .out_sum   (b_out_sum),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .ovf       (b_ovf),
        .drop_err  (b_drop)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every completed handshake on the GUARD=2 instance pops one expected frame.
    always @(negedge clk) begin
        if (reset_n && a_out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("frame_sum_a", 32'(a_out_sum), e.sa);
                check("frame_ovf_a", 32'(a_ovf), 32'(e.oa));
                check("frame_valid_b", 32'(b_out_valid), 32'd1);
                check("frame_sum_b", 32'(b_out_sum), e.sb);
                check("frame_ovf_b", 32'(b_ovf), 32'(e.ob));
            end
        end
    end

    task automatic send(input logic [15:0] d);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int gaps[4];
        int unsigned run;
        gaps = '{0, 3, 1, 2};

        // Reset
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_out_sum", 32'(a_out_sum), 32'd0);
        check("rst_ovf", 32'(a_ovf), 32'd0);
        check("rst_drop", 32'(a_drop), 32'd0);
        check("rst_in_ready", 32'(a_in_ready), 32'd1);

        // 1: basic frame, immediate handshake
        out_ready = 1'b1;
        exp_q.push_back('{100, 0, 100, 0});
        send(10); send(20); send(30);
        check("t1_not_yet_valid", 32'(a_out_valid), 32'd0);
        send(40);
        check("t1_latency_valid", 32'(a_out_valid), 32'd1);
        check("t1_hold_in_ready", 32'(a_in_ready), 32'd0);
        idle_cycle();
        check("t1_valid_dropped", 32'(a_out_valid), 32'd0);
        check("t1_idle_in_ready", 32'(a_in_ready), 32'd1);

        // 2: backpressure and drop in HOLD; GUARD=1 instance overflows here
        out_ready = 1'b0;
        exp_q.push_back('{260100, 0, 129028, 1});
        repeat (4) send(16'd65025);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", 32'(a_out_valid), 32'd1);
            check("t2_hold_sum", 32'(a_out_sum), 32'd260100);
            check("t2_hold_in_ready", 32'(a_in_ready), 32'd0);
            idle_cycle();
        end
        check("t2_ovf_b_early", 32'(b_ovf), 32'd1);
        check("t2_drop_before", 32'(a_drop), 32'd0);
        send(16'd7);
        check("t2_drop_a", 32'(a_drop), 32'd1);
        check("t2_drop_b", 32'(b_drop), 32'd1);
        check("t2_sum_after_drop", 32'(a_out_sum), 32'd260100);
        check("t2_acc_after_drop", 32'(u_a.acc_q), 32'd0);
        out_ready = 1'b1;
        idle_cycle();
        check("t2_valid_fall", 32'(a_out_valid), 32'd0);
        check("t2_sum_kept", 32'(a_out_sum), 32'd260100);

        // 3: gapped input; accumulator must hold across idle cycles
        exp_q.push_back('{10, 0, 10, 1});
        run = 0;
        for (int i = 0; i < 4; i++) begin
            send(16'(i + 1));
            run += i + 1;
            if (i < 3) begin
                for (int g = 0; g < gaps[i]; g++) begin
                    idle_cycle();
                    check("t3_gap_acc", 32'(u_a.acc_q), run);
                    check("t3_gap_cnt", 32'(u_a.cnt_q), 32'(i + 1));
                    check("t3_gap_valid", 32'(a_out_valid), 32'd0);
                end
            end
        end
        idle_cycle();

        // 4: ovf stays sticky on the GUARD=1 instance, then clear drops it
        exp_q.push_back('{4, 0, 4, 1});
        repeat (4) send(16'd1);
        idle_cycle();
        clear = 1'b1;
        idle_cycle();
        clear = 1'b0;
        check("t4_clear_ovf_b", 32'(b_ovf), 32'd0);
        check("t4_clear_drop_a", 32'(a_drop), 32'd0);

        // 5: clear together with a valid sample
        send(16'd5); send(16'd6);
        clear = 1'b1;
        send(16'd7);
        clear = 1'b0;
        check("t5_cnt_cleared", 32'(u_a.cnt_q), 32'd0);
        check("t5_acc_cleared", 32'(u_a.acc_q), 32'd0);
        check("t5_no_drop", 32'(a_drop), 32'd0);
        exp_q.push_back('{4, 0, 4, 0});
        repeat (4) send(16'd1);
        idle_cycle();

        // 6: asynchronous reset while holding a frame
        out_ready = 1'b0;
        repeat (4) send(16'd25);
        check("t6_hold_valid", 32'(a_out_valid), 32'd1);
        check("t6_hold_sum", 32'(a_out_sum), 32'd100);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(a_out_valid), 32'd0);
        check("t6_async_sum", 32'(a_out_sum), 32'd0);
        check("t6_async_in_ready", 32'(a_in_ready), 32'd1);
        idle_cycle();
        reset_n = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back('{8, 0, 8, 0});
        repeat (4) send(16'd2);
        idle_cycle();

        repeat (3) idle_cycle();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
